// File: rtl/oled_spi_receiver_if.sv
// Bus bundle between an SPI display-write master and the OLED receiver.
// The master drives the serial pins; the receiver returns byte and frame-buffer strobes.
`timescale 1ns/1ps
interface oled_spi_receiver_if;
    logic       SCLK;
    logic       nCS;
    logic       DnC;
    logic       SDIN;
    logic [7:0] RxByte;
    logic       RxValid;
    logic       RxIsData;
    logic       WrEn;
    logic [9:0] WrAddr;
    logic [7:0] WrData;
    logic       CmdValid;
    logic       FrameErr;

    modport master (
        output SCLK, nCS, DnC, SDIN,
        input  RxByte, RxValid, RxIsData, WrEn, WrAddr, WrData, CmdValid, FrameErr
    );

    modport slave (
        input  SCLK, nCS, DnC, SDIN,
        output RxByte, RxValid, RxIsData, WrEn, WrAddr, WrData, CmdValid, FrameErr
    );
endinterface

// File: rtl/oled_spi_receiver.sv
// SPI slave for an OLED controller: deserialises bytes, decodes page/column
// commands and turns data bytes into frame-buffer writes with auto-increment.
`timescale 1ns/1ps
module oled_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int COL_MAX     = 127
) (
    input logic               Clock,
    input logic               nReset,
    oled_spi_receiver_if.slave bus
);

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] dnc_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   sclk_s;
    logic                   ncs_s;
    logic                   dnc_s;
    logic                   sdin_s;
    logic                   sclk_prev;
    logic                   sclk_rise;
    logic [7:0]             shift_reg;
    logic [7:0]             next_byte;
    logic [2:0]             bit_cnt;
    logic [2:0]             page;
    logic [6:0]             col;
    logic [7:0]             rx_byte;
    logic                   rx_valid;
    logic                   rx_is_data;
    logic                   wr_en;
    logic [9:0]             wr_addr;
    logic [7:0]             wr_data;
    logic                   cmd_valid;
    logic                   frame_err;

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            dnc_sync  <= '0;
            sdin_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0],  bus.nCS};
            dnc_sync  <= {dnc_sync[SYNC_STAGES-2:0],  bus.DnC};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], bus.SDIN};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign dnc_s     = dnc_sync[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev & ~ncs_s;
    assign next_byte = {shift_reg[6:0], sdin_s};

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b[7:3] == 5'b10110) || (b[7:4] == 4'h0) || (b[7:3] == 5'b00010);
    endfunction

    // Byte assembly; all strobes and write fields are registered so they
    // appear together in the cycle after the eighth counted edge.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            rx_is_data <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            wr_en     <= 1'b0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (ncs_s) begin
                if (bit_cnt != 3'd0) begin
                    frame_err <= 1'b1;
                    bit_cnt   <= 3'd0;
                end
            end else if (sclk_rise) begin
                shift_reg <= next_byte;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_valid   <= 1'b1;
                    rx_byte    <= next_byte;
                    rx_is_data <= dnc_s;
                    wr_en      <= dnc_s;
                    cmd_valid  <= !dnc_s && !is_known_cmd(next_byte);
                    if (dnc_s) begin
                        wr_addr <= {page, col};
                        wr_data <= next_byte;
                    end
                end
            end
        end
    end

    // Address state moves only when a byte is presented.
    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            page <= '0;
            col  <= '0;
        end else if (rx_valid) begin
            if (rx_is_data) begin
                col <= (col == 7'(COL_MAX)) ? 7'd0 : col + 7'd1;
            end else if (rx_byte[7:3] == 5'b10110) begin
                page <= rx_byte[2:0];
            end else if (rx_byte[7:4] == 4'h0) begin
                col[3:0] <= rx_byte[3:0];
            end else if (rx_byte[7:3] == 5'b00010) begin
                col[6:4] <= rx_byte[2:0];
            end
        end
    end

    assign bus.RxByte   = rx_byte;
    assign bus.RxValid  = rx_valid;
    assign bus.RxIsData = rx_is_data;
    assign bus.WrEn     = wr_en;
    assign bus.WrAddr   = wr_addr;
    assign bus.WrData   = wr_data;
    assign bus.CmdValid = cmd_valid;
    assign bus.FrameErr = frame_err;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Scoreboard bench for oled_spi_receiver: stimulus queues expected strobes,
// a negedge monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps
module tb_oled_spi_receiver;

    typedef struct {
        logic       is_err;
        logic [7:0] b;
        logic       d;
        logic [9:0] addr;
        logic       cmd;
    } exp_t;

    logic clock = 1'b0;
    logic n_reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rx_count = 0;
    int   rx_mark;
    exp_t exp_q[$];
    exp_t e;

    oled_spi_receiver_if bus();

    oled_spi_receiver #(.SYNC_STAGES(2), .COL_MAX(127)) dut (
        .Clock  (clock),
        .nReset (n_reset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clock) begin
        if (n_reset && (bus.RxValid || bus.FrameErr || bus.WrEn || bus.CmdValid)) begin
            if (bus.RxValid) rx_count++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_strobe: got RxValid=%b FrameErr=%b WrEn=%b CmdValid=%b, expected none",
                         bus.RxValid, bus.FrameErr, bus.WrEn, bus.CmdValid);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err) begin
                    check_output("frame_err", 32'(bus.FrameErr), 32'd1);
                    check_output("rx_valid_on_err", 32'(bus.RxValid), 32'd0);
                end else begin
                    check_output("rx_valid", 32'(bus.RxValid), 32'd1);
                    check_output("frame_err_on_byte", 32'(bus.FrameErr), 32'd0);
                    check_output("rx_byte", 32'(bus.RxByte), 32'(e.b));
                    check_output("rx_is_data", 32'(bus.RxIsData), 32'(e.d));
                    check_output("wr_en", 32'(bus.WrEn), 32'(e.d));
                    check_output("cmd_valid", 32'(bus.CmdValid), 32'(e.cmd));
                    if (e.d) begin
                        check_output("wr_addr", 32'(bus.WrAddr), 32'(e.addr));
                        check_output("wr_data", 32'(bus.WrData), 32'(e.b));
                    end
                end
            end
        end
    end

    task automatic shift_bits(input logic [7:0] b, input int nbits, input logic d);
        bus.DnC = d;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.SCLK = 1'b0;
            bus.SDIN = b[i];
            #20;
            bus.SCLK = 1'b1;
            #20;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic d, input logic [9:0] addr, input logic cmd);
        exp_t x;
        x.is_err = 1'b0;
        x.b = b;
        x.d = d;
        x.addr = addr;
        x.cmd = cmd;
        exp_q.push_back(x);
        shift_bits(b, 8, d);
    endtask

    task automatic frame_open();
        bus.SCLK = 1'b0;
        bus.nCS = 1'b0;
        #60;
    endtask

    task automatic frame_close();
        bus.SCLK = 1'b0;
        #20;
        bus.nCS = 1'b1;
        #80;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clock);
        check_output(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_rx_byte"}, 32'(bus.RxByte), 32'd0);
        check_output({tag, "_rx_valid"}, 32'(bus.RxValid), 32'd0);
        check_output({tag, "_rx_is_data"}, 32'(bus.RxIsData), 32'd0);
        check_output({tag, "_wr_en"}, 32'(bus.WrEn), 32'd0);
        check_output({tag, "_wr_addr"}, 32'(bus.WrAddr), 32'd0);
        check_output({tag, "_wr_data"}, 32'(bus.WrData), 32'd0);
        check_output({tag, "_cmd_valid"}, 32'(bus.CmdValid), 32'd0);
        check_output({tag, "_frame_err"}, 32'(bus.FrameErr), 32'd0);
    endtask

    initial begin
        exp_t x;
        bus.SCLK = 1'b0;
        bus.nCS  = 1'b1;
        bus.DnC  = 1'b0;
        bus.SDIN = 1'b0;
        #23;
        check_all_zero("reset");
        n_reset = 1'b1;
        #60;

        $display("[TB] single data byte");
        frame_open();
        apply_stimulus(8'hA5, 1'b1, 10'h000, 1'b0);
        frame_close();
        drain("drain_single");

        $display("[TB] page/column commands then data");
        frame_open();
        apply_stimulus(8'hB3, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h05, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h12, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h3C, 1'b1, 10'h1A5, 1'b0);
        frame_close();
        drain("drain_cmds");

        $display("[TB] column wrap");
        frame_open();
        apply_stimulus(8'hB2, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h0F, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h17, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h01, 1'b1, 10'h17F, 1'b0);
        apply_stimulus(8'h02, 1'b1, 10'h100, 1'b0);
        frame_close();
        drain("drain_wrap");

        $display("[TB] aborted byte then unknown command");
        frame_open();
        shift_bits(8'hFF, 5, 1'b1);
        x.is_err = 1'b1;
        x.b = 8'h00;
        x.d = 1'b0;
        x.addr = 10'h000;
        x.cmd = 1'b0;
        exp_q.push_back(x);
        frame_close();
        drain("drain_abort");
        frame_open();
        apply_stimulus(8'h81, 1'b0, 10'h000, 1'b1);
        frame_close();
        drain("drain_unknown_cmd");

        $display("[TB] back-to-back data bytes");
        frame_open();
        apply_stimulus(8'hB0, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h00, 1'b0, 10'h000, 1'b0);
        apply_stimulus(8'h10, 1'b0, 10'h000, 1'b0);
        frame_close();
        drain("drain_home");
        rx_mark = rx_count;
        frame_open();
        apply_stimulus(8'h11, 1'b1, 10'h000, 1'b0);
        apply_stimulus(8'h22, 1'b1, 10'h001, 1'b0);
        apply_stimulus(8'h33, 1'b1, 10'h002, 1'b0);
        apply_stimulus(8'h44, 1'b1, 10'h003, 1'b0);
        frame_close();
        drain("drain_burst");
        check_output("burst_rx_count", 32'(rx_count - rx_mark), 32'd4);
        frame_open();
        apply_stimulus(8'h55, 1'b1, 10'h004, 1'b0);
        frame_close();
        drain("drain_after_burst");

        $display("[TB] reset mid-byte");
        frame_open();
        shift_bits(8'hE0, 3, 1'b1);
        n_reset = 1'b0;
        #13;
        check_all_zero("midreset");
        bus.SCLK = 1'b0;
        bus.nCS = 1'b1;
        #40;
        n_reset = 1'b1;
        #100;
        check_output("post_reset_queue", 32'(exp_q.size()), 32'd0);
        frame_open();
        apply_stimulus(8'h5A, 1'b1, 10'h000, 1'b0);
        frame_close();
        drain("drain_post_reset");

        #100;
        check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/oled_spi_receiver.md
OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth on SCLK/nCS/DnC/SDIN (legal range 2..3).
REQ-002 SHALL have parameter COL_MAX, default 127, giving the last column index before wrap.
REQ-003 SHALL have port Clock, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port SCLK, input, 1 bit: serial clock from the display-write master, asynchronous to Clock.
REQ-006 SHALL have port nCS, input, 1 bit: active-low chip select.
REQ-007 SHALL have port DnC, input, 1 bit: 1 = data byte, 0 = command byte.
REQ-008 SHALL have port SDIN, input, 1 bit: serial data, MSB first.
REQ-009 SHALL have port RxByte, output, 8 bits: the last complete byte received.
REQ-010 SHALL have port RxValid, output, 1 bit: one-cycle strobe marking a new RxByte.
REQ-011 SHALL have port RxIsData, output, 1 bit: the DnC value captured with RxByte.
REQ-012 SHALL have port WrEn, output, 1 bit: one-cycle frame-buffer write strobe.
REQ-013 SHALL have port WrAddr, output, 10 bits: write address {page[2:0], col[6:0]}.
REQ-014 SHALL have port WrData, output, 8 bits: frame-buffer write data.
REQ-015 SHALL have port CmdValid, output, 1 bit: one-cycle strobe for a command not decoded internally.
REQ-016 SHALL have port FrameErr, output, 1 bit: one-cycle strobe marking a byte aborted by nCS.

Function
REQ-017 SHALL pass SCLK, nCS, DnC and SDIN each through SYNC_STAGES flops on Clock; all logic after this point uses only the synchronised copies.
REQ-018 SHALL detect an SCLK rising edge as sync SCLK = 1 with the previous cycle's sync SCLK = 0; the edge counts only when sync nCS = 0 in the same cycle.
REQ-019 On each counted edge, SHALL shift sync SDIN into an 8-bit shift register, MSB first, and increment a 3-bit bit counter.
REQ-020 On the counted edge where the bit counter = 7, SHALL, in the next cycle: load RxByte with the completed byte, load RxIsData with sync DnC sampled on that edge, pulse RxValid high for exactly 1 cycle, and reset the counter to 0.
REQ-021 SHALL receive back-to-back bytes within one nCS-low frame with no gap; SCLK frequency is at most Clock/4.
REQ-022 SHALL ignore SCLK edges while sync nCS = 1; the shift register contents are don't-care.
REQ-023 SHALL handle sync nCS going 1 while the bit counter ≠ 0 by: discarding the partial byte, clearing the counter, and pulsing FrameErr for 1 cycle; RxValid SHALL NOT pulse.
REQ-024 SHALL treat an SCLK edge in the same cycle as nCS deassertion per REQ-018 (edge ignored), then apply REQ-023.
REQ-025 SHALL decode command bytes (RxIsData = 0) in the RxValid cycle:
- 0xB0-0xB7: page <= byte[2:0]
- 0x00-0x0F: col[3:0] <= byte[3:0]
- 0x10-0x17: col[6:4] <= byte[2:0]
- any other command: CmdValid pulse in the same cycle as RxValid
REQ-026 SHALL, for a data byte (RxIsData = 1), in the RxValid cycle: set WrEn = 1, WrAddr = {page, col} as held before the update, WrData = RxByte; col then advances.
REQ-027 SHALL advance col as col+1, wrapping from COL_MAX to 0 with page unchanged.
REQ-028 SHALL update address state only on RxValid; there is no other path to change page or col.
REQ-029 SHALL hold WrAddr and WrData stable between strobes.

Reset
REQ-030 On nReset = 0, SHALL asynchronously clear all synchroniser flops, shift register, bit counter, page and col, and drive all outputs to 0.
REQ-031 SHALL clear synchroniser flops to SCLK = 0, nCS = 1, DnC = 0, SDIN = 0.
REQ-032 SHALL release reset synchronously; a reset asserted mid-byte discards the partial byte with no strobe of any kind.

Verification
REQ-033 Bench SHALL cover: nCS low, DnC = 1, send 0xA5 -> one RxValid, RxByte = 0xA5, RxIsData = 1, WrEn, WrAddr = 0x000, WrData = 0xA5.
REQ-034 Bench SHALL cover: commands 0xB3, 0x05, 0x12, then data 0x3C -> WrAddr = {3'd3, 7'h25} = 0x1A5, WrData = 0x3C, no CmdValid.
REQ-035 Bench SHALL cover: set col 127 on page 2, send data 0x01 then 0x02 -> WrAddr 0x17F then 0x100.
REQ-036 Bench SHALL cover: send 5 bits, raise nCS -> FrameErr one pulse, no RxValid; next full byte 0x81 (DnC = 0) -> RxByte = 0x81, CmdValid = 1.
REQ-037 Bench SHALL cover: 4 back-to-back data bytes at SCLK = Clock/4 -> 4 RxValid pulses, col advances by 4.
REQ-038 Bench SHALL cover: nReset pulsed after 3 bits -> all outputs 0, no strobe; next full byte is received correctly.
